// File: rtl/tlc_pkg.sv
// Shared encodings and the phase-duration lookup
// for the intersection phase sequencer.
package tlc_pkg;

  localparam logic [2:0] ST_HGRE  = 3'd0;
  localparam logic [2:0] ST_HYEL  = 3'd1;
  localparam logic [2:0] ST_ARED1 = 3'd2;
  localparam logic [2:0] ST_FGRE  = 3'd3;
  localparam logic [2:0] ST_FYEL  = 3'd4;
  localparam logic [2:0] ST_ARED2 = 3'd5;

  typedef enum logic [2:0] {
    HGRE  = ST_HGRE,
    HYEL  = ST_HYEL,
    ARED1 = ST_ARED1,
    FGRE  = ST_FGRE,
    FYEL  = ST_FYEL,
    ARED2 = ST_ARED2
  } state_e;

  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_RED = 3'b100;

  function automatic int unsigned dur_m1(
    input state_e      s,
    input int unsigned t_hg,
    input int unsigned t_y,
    input int unsigned t_ar,
    input int unsigned t_fg
  );
    int unsigned d;
    case (s)
      HYEL, FYEL:   d = t_y;
      ARED1, ARED2: d = t_ar;
      FGRE:         d = t_fg;
      default:      d = t_hg;
    endcase
    return d - 1;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter for phase durations;
// decrements only on tick and saturates at zero.
module tlc_phase_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (tick_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Six-phase highway/farm light sequencer with a
// latched farm-road request and tick-timed phases.
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_HGRE_MIN = 20,
  parameter int unsigned T_YEL      = 4,
  parameter int unsigned T_ARED     = 2,
  parameter int unsigned T_FGRE     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       C,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic [2:0] phase,
  output logic       farm_ack
);

  state_e           state_q, state_d, nxt;
  logic             req_q, req_d;
  logic             ack_q, ack_d;
  logic             legal, adv, load;
  logic             enter_f, zero;
  logic [CNT_W-1:0] load_val;

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_HGRE_MIN - 1))
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .load_i     (load),
    .load_val_i (load_val),
    .zero_o     (zero)
  );

  always_comb begin
    nxt   = HGRE;
    legal = 1'b1;
    case (state_q)
      HGRE:    nxt = HYEL;
      HYEL:    nxt = ARED1;
      ARED1:   nxt = FGRE;
      FGRE:    nxt = FYEL;
      FYEL:    nxt = ARED2;
      ARED2:   nxt = HGRE;
      default: legal = 1'b0;
    endcase
    // C is used directly so a same-edge request exits HGRE
    adv = legal && tick && zero &&
          ((state_q != HGRE) || req_q || C);
    load     = adv || !legal;
    state_d  = load ? nxt : state_q;
    load_val = CNT_W'(dur_m1(nxt, T_HGRE_MIN,
                             T_YEL, T_ARED, T_FGRE));
    enter_f  = adv && (nxt == FGRE);
    req_d    = enter_f ? 1'b0 :
               (req_q | (C && (state_q != FGRE)));
    ack_d    = enter_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HGRE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    light_highway = LT_RED;
    light_farm    = LT_RED;
    case (state_q)
      HGRE: light_highway = LT_GRN;
      HYEL: light_highway = LT_YEL;
      FGRE: light_farm    = LT_GRN;
      FYEL: light_farm    = LT_YEL;
      default: ;
    endcase
  end

  assign phase    = state_q;
  assign farm_ack = ack_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Scoreboard bench: a phase/time-left model predicts
// every post-edge output; a monitor compares them.
module tb_tlc_phase_sequencer;

  typedef struct packed {
    logic [2:0] lh;
    logic [2:0] lf;
    logic [2:0] ph;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       C = 1'b0;
  logic [2:0] light_highway, light_farm, phase;
  logic       farm_ack;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];

  int  dur [6] = '{3, 2, 1, 4, 2, 1};
  int  m_ph, m_left;
  bit  m_pend, m_ack;

  always #5 clk = ~clk;

  tlc_phase_sequencer #(
    .CNT_W(8), .T_HGRE_MIN(3), .T_YEL(2),
    .T_ARED(1), .T_FGRE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .C(C),
    .light_highway(light_highway),
    .light_farm(light_farm),
    .phase(phase), .farm_ack(farm_ack)
  );

  function automatic exp_t mk_exp(int ph, bit ack);
    exp_t e;
    e.ph  = 3'(ph);
    e.ack = ack;
    case (ph)
      0: begin e.lh = 3'b001; e.lf = 3'b100; end
      1: begin e.lh = 3'b010; e.lf = 3'b100; end
      3: begin e.lh = 3'b100; e.lf = 3'b001; end
      4: begin e.lh = 3'b100; e.lf = 3'b010; end
      default: begin e.lh = 3'b100; e.lf = 3'b100; end
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = dur[0]; m_pend = 0; m_ack = 0;
  endtask

  // one clock edge of the reference model
  task automatic model_edge(bit t, bit c);
    int  old_ph;
    bit  enter_f;
    old_ph  = m_ph;
    enter_f = 0;
    m_ack   = 0;
    if (t) begin
      if (m_left > 1) m_left--;
      else if (m_ph != 0 || m_pend || c) begin
        m_ph    = (m_ph + 1) % 6;
        m_left  = dur[m_ph];
        enter_f = (m_ph == 3);
        m_ack   = enter_f;
      end
    end
    if (enter_f) m_pend = 0;
    else if (c && old_ph != 3) m_pend = 1;
  endtask

  task automatic step(bit t, bit c);
    @(negedge clk);
    tick = t;
    C    = c;
    model_edge(t, c);
    sb.push_back(mk_exp(m_ph, m_ack));
  endtask

  task automatic chk(string nm, logic [11:0] act,
                     logic [11:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  always begin
    exp_t e, a;
    @(posedge clk);
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      a = {light_highway, light_farm, phase, farm_ack};
      chk("scoreboard lh/lf/ph/ack",
          {2'b0, a}, {2'b0, e});
    end
  end

  task automatic run_until(int ph, string nm);
    int guard = 0;
    while (m_ph != ph && guard < 200) begin
      step(1, 0);
      guard++;
    end
    if (m_ph != ph) chk(nm, 12'd0, 12'd1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset lights",
        {6'b0, light_highway, light_farm},
        {6'b0, 3'b001, 3'b100});
    chk("reset phase/ack", {8'b0, phase, farm_ack},
        {8'b0, 3'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) step(1, 0);
    for (int i = 0; i < 30; i++) step(1, i == 10);
    for (int i = 0; i < 45; i++) step(1, 1);
    for (int i = 0; i < 20; i++) step(1, 0);
    for (int i = 0; i < 80; i++) step(i % 4 == 0, i == 5);
    for (int i = 0; i < 10; i++) step(1, 0);

    step(1, 1);
    run_until(3, "reach FGRE");
    step(1, 1);
    for (int i = 0; i < 40; i++) step(1, 0);
    chk("FGRE pulse ignored", {9'b0, 3'(m_ph)}, 12'd0);

    step(1, 1);
    run_until(4, "reach FYEL");
    step(1, 1);
    for (int i = 0; i < 25; i++) step(1, 0);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));

    step(1, 1);
    run_until(3, "reach FGRE for reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    tick  = 1'b0;
    C     = 1'b0;
    #1;
    chk("async reset lights",
        {6'b0, light_highway, light_farm},
        {6'b0, 3'b001, 3'b100});
    chk("async reset phase/ack", {8'b0, phase, farm_ack},
        {8'b0, 3'd0, 1'b0});
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 0);
    for (int i = 0; i < 12; i++) step(1, i == 2);

    @(posedge clk);
    #3;
    chk("scoreboard drained", 12'(sb.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
